// File: rtl/sprite_pkg.sv
// Shared types, sizes and sprite geometry tables for the sprite fetch pipeline.
package sprite_pkg;

  localparam int unsigned SPRITE_ADDR_W = 11;
  localparam int unsigned COORD_W       = 5;
  localparam int unsigned COLOR_W       = 8;
  localparam int unsigned FIFO_DEPTH    = 4;
  localparam int unsigned FIFO_PTR_W    = 2;
  localparam int unsigned FIFO_CNT_W    = 3;

  localparam logic [COLOR_W-1:0] TRANSPARENT_KEY = 8'h00;

  typedef enum logic [2:0] {
    SPR_CANNONBALL    = 3'd0,
    SPR_DEMOMAN_R_RED = 3'd1,
    SPR_DEMOMAN_L_RED = 3'd2,
    SPR_DEMOMAN_R_BLU = 3'd3,
    SPR_DEMOMAN_L_BLU = 3'd4,
    SPR_SKY           = 3'd5,
    SPR_GROUND        = 3'd6,
    SPR_BLANKING      = 3'd7
  } sprite_id_t;

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic               transparent;
  } pix_t;

  function automatic logic [SPRITE_ADDR_W-1:0] sprite_base(input sprite_id_t id);
    case (id)
      SPR_CANNONBALL:    return SPRITE_ADDR_W'(0);
      SPR_DEMOMAN_R_RED: return SPRITE_ADDR_W'(204);
      SPR_DEMOMAN_L_RED: return SPRITE_ADDR_W'(579);
      SPR_DEMOMAN_R_BLU: return SPRITE_ADDR_W'(954);
      SPR_DEMOMAN_L_BLU: return SPRITE_ADDR_W'(1329);
      SPR_SKY:           return SPRITE_ADDR_W'(1704);
      SPR_GROUND:        return SPRITE_ADDR_W'(1705);
      default:           return SPRITE_ADDR_W'(1706);
    endcase
  endfunction

  function automatic logic [COORD_W-1:0] sprite_width(input sprite_id_t id);
    case (id)
      SPR_CANNONBALL:                                   return COORD_W'(12);
      SPR_DEMOMAN_R_RED, SPR_DEMOMAN_L_RED,
      SPR_DEMOMAN_R_BLU, SPR_DEMOMAN_L_BLU:             return COORD_W'(15);
      default:                                          return COORD_W'(1);
    endcase
  endfunction

  function automatic logic [COORD_W-1:0] sprite_height(input sprite_id_t id);
    case (id)
      SPR_CANNONBALL:                                   return COORD_W'(17);
      SPR_DEMOMAN_R_RED, SPR_DEMOMAN_L_RED,
      SPR_DEMOMAN_R_BLU, SPR_DEMOMAN_L_BLU:             return COORD_W'(25);
      default:                                          return COORD_W'(1);
    endcase
  endfunction

  function automatic logic sprite_is_1x1(input sprite_id_t id);
    return (id == SPR_SKY) || (id == SPR_GROUND) || (id == SPR_BLANKING);
  endfunction

endpackage

// File: rtl/sprite_fetch_if.sv
// Request/pixel handshake bundle for sprite_fetch.
// req_mirror exists only when SPRITE_FETCH_MIRROR_EN is defined.
interface sprite_fetch_if;
  import sprite_pkg::*;

  logic               req_valid;
  logic               req_ready;
  sprite_id_t         req_sprite;
  logic [COORD_W-1:0] req_x;
  logic [COORD_W-1:0] req_y;
`ifdef SPRITE_FETCH_MIRROR_EN
  logic               req_mirror;
`endif
  logic               pix_valid;
  logic               pix_ready;
  logic [COLOR_W-1:0] pix_color;
  logic               pix_transparent;

  modport master (
`ifdef SPRITE_FETCH_MIRROR_EN
    output req_mirror,
`endif
    output req_valid, req_sprite, req_x, req_y, pix_ready,
    input  req_ready, pix_valid, pix_color, pix_transparent
  );

  modport slave (
`ifdef SPRITE_FETCH_MIRROR_EN
    input  req_mirror,
`endif
    input  req_valid, req_sprite, req_x, req_y, pix_ready,
    output req_ready, pix_valid, pix_color, pix_transparent
  );

endinterface

// File: rtl/sprite_fetch_fifo.sv
// 4-entry show-ahead pixel buffer; head is valid whenever count is non-zero.
module sprite_fetch_fifo
  import sprite_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  pix_t                  push_data,
  input  logic                  pop,
  output logic                  valid,
  output pix_t                  head,
  output logic [FIFO_CNT_W-1:0] count
);

  pix_t                  mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic                  do_push_c;
  logic                  do_pop_c;

  always_comb begin
    do_pop_c  = pop && (count != '0);
    do_push_c = push && ((count != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + FIFO_PTR_W'(1);
      end
      if (do_pop_c) rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push_c, do_pop_c})
        2'b10:   count <= count + FIFO_CNT_W'(1);
        2'b01:   count <= count - FIFO_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign valid = (count != '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/sprite_fetch.sv
// Sprite pixel fetch: address generation, 2-cycle RAM pipeline, credit-controlled output FIFO.
// Optional horizontal mirroring via SPRITE_FETCH_MIRROR_EN.
module sprite_fetch
  import sprite_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  sprite_fetch_if.slave            bus,
  output logic [SPRITE_ADDR_W-1:0] read_address,
  input  logic [COLOR_W-1:0]       ram_data
);

  logic                     s1_valid;
  logic                     s1_oor;
  logic                     s2_valid;
  logic                     s2_oor;
  logic                     accept_c;
  logic                     pop_c;
  logic                     fifo_valid;
  logic [FIFO_CNT_W-1:0]    fifo_count;
  logic [FIFO_CNT_W-1:0]    credits_c;
  pix_t                     push_data_c;
  pix_t                     head;
  logic [COORD_W-1:0]       w_c;
  logic [COORD_W-1:0]       h_c;
  logic [COORD_W-1:0]       x_eff_c;
  logic                     single_c;
  logic                     oor_c;
  logic [SPRITE_ADDR_W-1:0] addr_c;

  // Every accepted pixel holds one credit until it leaves the FIFO.
  always_comb begin
    credits_c = FIFO_CNT_W'(s1_valid) + FIFO_CNT_W'(s2_valid) + fifo_count;
  end

  assign bus.req_ready = (credits_c < FIFO_CNT_W'(FIFO_DEPTH));
  assign accept_c      = bus.req_valid && bus.req_ready;

  always_comb begin
    w_c      = sprite_width(bus.req_sprite);
    h_c      = sprite_height(bus.req_sprite);
    single_c = sprite_is_1x1(bus.req_sprite);
    x_eff_c  = bus.req_x;
`ifdef SPRITE_FETCH_MIRROR_EN
    if (bus.req_mirror) x_eff_c = w_c - COORD_W'(1) - bus.req_x;
`endif
    // A mirrored x beyond the width wraps to >= width, so it stays out of range.
    oor_c  = !single_c && ((x_eff_c >= w_c) || (bus.req_y >= h_c));
    addr_c = sprite_base(bus.req_sprite);
    if (!single_c) begin
      addr_c = sprite_base(bus.req_sprite)
             + SPRITE_ADDR_W'(bus.req_y) * SPRITE_ADDR_W'(w_c)
             + SPRITE_ADDR_W'(x_eff_c);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid     <= 1'b0;
      s1_oor       <= 1'b0;
      s2_valid     <= 1'b0;
      s2_oor       <= 1'b0;
      read_address <= '0;
    end else begin
      s1_valid <= accept_c;
      s2_valid <= s1_valid;
      s2_oor   <= s1_oor;
      if (accept_c) begin
        read_address <= addr_c;
        s1_oor       <= oor_c;
      end
    end
  end

  // Out-of-range pixels ignore RAM contents entirely.
  always_comb begin
    push_data_c.color       = ram_data;
    push_data_c.transparent = (ram_data == TRANSPARENT_KEY);
    if (s2_oor) begin
      push_data_c.color       = TRANSPARENT_KEY;
      push_data_c.transparent = 1'b1;
    end
  end

  assign pop_c = fifo_valid && bus.pix_ready;

  sprite_fetch_fifo u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (s2_valid),
    .push_data (push_data_c),
    .pop       (pop_c),
    .valid     (fifo_valid),
    .head      (head),
    .count     (fifo_count)
  );

  assign bus.pix_valid       = fifo_valid;
  assign bus.pix_color       = head.color;
  assign bus.pix_transparent = head.transparent;

endmodule

// File: tb/tb_sprite_fetch.sv
// Self-checking bench for sprite_fetch: directed steps plus random traffic against a queue model.
module tb_sprite_fetch;
  import sprite_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] read_address;
  logic [7:0]  ram_data;
  logic [7:0]  ram [2048];

  sprite_fetch_if bus ();

  sprite_fetch dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .read_address (read_address),
    .ram_data     (ram_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read sprite RAM.
  always @(posedge clk) ram_data <= ram[read_address];

  int base_t   [8] = '{0, 204, 579, 954, 1329, 1704, 1705, 1706};
  int width_t  [8] = '{12, 15, 15, 15, 15, 1, 1, 1};
  int height_t [8] = '{17, 25, 25, 25, 25, 1, 1, 1};

  typedef struct {
    logic [7:0] color;
    logic       tr;
    int         acc_cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   n_dut_acc = 0;
  int   last_addr = 0;
  bit   last_known = 1'b1;
  int   cur_id = 0, cur_x = 0, cur_y = 0;
  bit   cur_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t predict(input int id, input int x, input int y, input bit m,
                                   output int addr, output bit known);
    exp_t e;
    int   w, h, xe;
    w = width_t[id];
    h = height_t[id];
    xe = m ? (w - 1 - x) : x;
    e.acc_cyc = 0;
    known = 1'b1;
    addr = 0;
    if (id >= 5) begin
      addr    = base_t[id];
      e.color = ram[11'(addr)];
      e.tr    = (e.color == 8'h00);
    end else if (xe < 0 || xe >= w || y >= h) begin
      known   = 1'b0;
      e.color = 8'h00;
      e.tr    = 1'b1;
    end else begin
      addr    = base_t[id] + y * w + xe;
      e.color = ram[11'(addr)];
      e.tr    = (e.color == 8'h00);
    end
    return e;
  endfunction

  task automatic set_req(input bit v, input int id, input int x, input int y, input bit m);
    cur_id = id; cur_x = x; cur_y = y; cur_m = m;
    bus.req_valid  = v;
    bus.req_sprite = sprite_id_t'(3'(id));
    bus.req_x      = 5'(x);
    bus.req_y      = 5'(y);
`ifdef SPRITE_FETCH_MIRROR_EN
    bus.req_mirror = m;
`endif
  endtask

  // One clock: check outputs against the model, advance model on the edge, check address.
  task automatic tick();
    bit   exp_ready, exp_valid, acc, pop, ak;
    exp_t e;
    int   a;
    exp_ready = (q.size() < 4);
    exp_valid = 1'b0;
    if (q.size() > 0) exp_valid = (q[0].acc_cyc + 2 <= cyc);
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    chk("pix_valid", 32'(bus.pix_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("pix_color", 32'(bus.pix_color), 32'(q[0].color));
      chk("pix_transparent", 32'(bus.pix_transparent), 32'(q[0].tr));
    end
    acc = bus.req_valid && exp_ready;
    pop = exp_valid && bus.pix_ready;
    a = 0; ak = 1'b0;
    e = '{color: 8'h00, tr: 1'b0, acc_cyc: 0};
    if (acc) e = predict(cur_id, cur_x, cur_y, cur_m, a, ak);
    if (bus.req_valid && bus.req_ready) n_dut_acc++;
    @(posedge clk);
    cyc++;
    if (pop) q.delete(0);
    if (acc) begin
      e.acc_cyc = cyc;
      q.push_back(e);
    end
    #1;
    if (acc) begin
      if (ak) begin
        chk("read_address", 32'(read_address), 32'(a));
        last_addr = a;
        last_known = 1'b1;
      end else begin
        last_known = 1'b0;
      end
    end else if (last_known) begin
      chk("read_address_hold", 32'(read_address), 32'(last_addr));
    end
    @(negedge clk);
  endtask

  task automatic drain(input int max);
    int n = 0;
    set_req(1'b0, 0, 0, 0, 1'b0);
    bus.pix_ready = 1'b1;
    while (q.size() > 0 && n < max) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 8'($urandom_range(1, 255));
    ram[251]  = 8'h5A;
    ram[27]   = 8'h00;
    ram[219]  = 8'hFF;
    ram[1704] = 8'h3C;
    ram[23]   = 8'h77;
    set_req(1'b0, 0, 0, 0, 1'b0);
    bus.pix_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
    chk("rst_read_address", 32'(read_address), 32'd0);
    chk("rst_pix_color", 32'(bus.pix_color), 32'd0);
    chk("rst_pix_transparent", 32'(bus.pix_transparent), 32'd0);
    reset_n = 1'b1;

    // Single request, exact latency
    set_req(1'b1, 1, 2, 3, 1'b0);
    tick();
    set_req(1'b0, 0, 0, 0, 1'b0);
    repeat (4) tick();

    // Back-to-back sprite 0 row 0
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 0, i, 0, 1'b0);
      tick();
    end
    drain(20);

    // Backpressure: exactly four credits
    bus.pix_ready = 1'b0;
    n_dut_acc = 0;
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 2, $urandom_range(0, 14), $urandom_range(0, 24), 1'b0);
      tick();
    end
    chk("credit_accepts", 32'(n_dut_acc), 32'd4);
    bus.pix_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 3, $urandom_range(0, 14), $urandom_range(0, 24), 1'b0);
      tick();
    end
    drain(20);

    // Boundaries: out of range, 1x1 sprite, zero byte in range
    set_req(1'b1, 1, 15, 0, 1'b0);  tick();
    set_req(1'b1, 1, 3, 25, 1'b0);  tick();
    set_req(1'b1, 5, 9, 9, 1'b0);   tick();
    set_req(1'b1, 0, 3, 2, 1'b0);   tick();
    set_req(1'b1, 7, 31, 31, 1'b0); tick();
    drain(20);

`ifdef SPRITE_FETCH_MIRROR_EN
    set_req(1'b1, 0, 0, 1, 1'b1); tick();
    set_req(1'b1, 4, 20, 3, 1'b1); tick();
    drain(20);
`endif

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      int  x;
      bit  m;
      x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 14));
      m = 1'b0;
`ifdef SPRITE_FETCH_MIRROR_EN
      m = 1'($urandom_range(0, 1));
`endif
      bus.pix_ready = ($urandom_range(0, 3) != 0);
      set_req($urandom_range(0, 3) != 0, $urandom_range(0, 7), x,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 16)), m);
      tick();
    end
    drain(40);

    // Reset with three pixels buffered
    bus.pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 0, i, 1, 1'b0);
      tick();
    end
    set_req(1'b0, 0, 0, 0, 1'b0);
    repeat (3) tick();
    chk("buffered_before_reset", 32'(q.size()), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_pix_valid", 32'(bus.pix_valid), 32'd0);
    chk("async_rst_read_address", 32'(read_address), 32'd0);
    chk("async_rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("async_rst_pix_color", 32'(bus.pix_color), 32'd0);
    q.delete();
    last_addr = 0;
    last_known = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus.pix_ready = 1'b1;
    repeat (6) tick();

    // Traffic resumes cleanly after reset
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 6, i, i, 1'b0);
      tick();
    end
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_fetch.md
SPRITE_FETCH -- requirements
Module: sprite_fetch

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock for all state; reset_n input 1, asynchronous active-low reset.
REQ-002 req_valid input 1: pixel request present.
REQ-003 req_ready output 1: request accepted on the clk edge where req_valid=1 and req_ready=1.
REQ-004 req_sprite input 3: sprite_id_t (0 cannonball, 1 demomanR_red, 2 demomanL_red, 3 demomanR_blu, 4 demomanL_blu, 5 sky, 6 ground, 7 blanking).
REQ-005 req_x input 5, req_y input 5: pixel column and row within the sprite.
REQ-006 read_address output 11: sprite RAM read address, registered.
REQ-007 ram_data input 8: sprite RAM data_out, valid one clk after read_address changes.
REQ-008 pix_valid output 1, pix_ready input 1: output handshake; a transfer occurs when both are 1.
REQ-009 pix_color output 8: palette byte.
REQ-010 pix_transparent output 1: pixel is not to be drawn.

Function
REQ-011 Address SHALL be BASE[id] + y*WIDTH[id] + x, computed in 11 bits; no overflow is possible with the table.
REQ-012 For 1x1 sprites (ids 5, 6, 7) the address SHALL be BASE[id], and req_x/req_y SHALL be ignored.
REQ-013 Pipeline: s1 (read_address registered, s1_valid), s2 (ram_data valid, s2_valid), then a 4-entry output FIFO written from s2.
REQ-014 A request accepted at edge N SHALL appear on pix_valid/pix_color from edge N+2 when the FIFO is empty; latency SHALL be exactly 2 cycles.
REQ-015 req_ready SHALL be 1 iff s1_valid + s2_valid + fifo_count < 4 (credit scheme), giving 1 pixel/cycle sustained with pix_ready=1.
REQ-016 When no request is accepted, read_address SHALL hold its value.
REQ-017 Pixels SHALL leave in acceptance order; none may be dropped or duplicated.
REQ-018 A request with x >= WIDTH or y >= HEIGHT (multi-pixel sprites only) SHALL yield pix_transparent=1 and pix_color=TRANSPARENT_KEY, independent of ram_data.
REQ-019 Otherwise pix_transparent SHALL equal (ram_data == TRANSPARENT_KEY), and pix_color SHALL equal ram_data.
REQ-020 A simultaneous FIFO push and pop SHALL leave fifo_count unchanged.
REQ-021 When the FIFO is full no push can occur, by REQ-015.
REQ-022 Between requests, pix_color and pix_transparent SHALL hold the FIFO head value while pix_valid=1.

Reset
REQ-023 On reset_n=0 the following SHALL be cleared immediately: s1_valid, s2_valid, FIFO (count 0, pointers 0), read_address=0, pix_valid=0, pix_color=0, pix_transparent=0.
REQ-024 req_ready SHALL be 1 on the first cycle after reset release.
REQ-025 Reset mid-operation SHALL discard all in-flight and buffered pixels; no stale pixel may emerge after release.

Configuration
REQ-026 With SPRITE_FETCH_MIRROR_EN defined, an input req_mirror (1 bit) SHALL exist and, when 1, replace x with WIDTH[id]-1-x before the range check and address calculation.
REQ-027 Without SPRITE_FETCH_MIRROR_EN, req_mirror SHALL be absent and no mirroring logic SHALL exist.

Structure
REQ-028 Package sprite_pkg SHALL hold:
- sprite_id_t
- SPRITE_ADDR_W=11
- TRANSPARENT_KEY=8'h00
- BASE table: 0, 204, 579, 954, 1329, 1704, 1705, 1706
- WIDTH table: 12, 15, 15, 15, 15, 1, 1, 1
- HEIGHT table: 17, 25, 25, 25, 25, 1, 1, 1
REQ-029 The output buffer SHALL be a sub-module, sprite_fetch_fifo (4x9 bits: color + transparent, show-ahead).

Verification
REQ-030 Reset with req_valid=0 -> req_ready=1, pix_valid=0, read_address=0.
REQ-031 Sprite 1, x=2, y=3, pix_ready=1 -> read_address=251 one edge after acceptance; pix_valid two edges after, with pix_color=RAM[251].
REQ-032 8 back-to-back requests (sprite 0, x=0..7, y=0), pix_ready=1 -> addresses 0..7, 8 pixels on consecutive cycles, in order.
REQ-033 pix_ready=0 with continuous requests -> exactly 4 accepted, then req_ready=0; with pix_ready=1 -> those 4 emerge in order, then acceptance resumes.
REQ-034 Sprite 1, x=15 -> pix_transparent=1, pix_color=8'h00. Sprite 5, x=9, y=9 -> read_address=1704. A RAM byte of 8'h00 in range -> pix_transparent=1.
REQ-035 SPRITE_FETCH_MIRROR_EN defined: sprite 0, x=0, y=1, req_mirror=1 -> read_address=23. Reset asserted with 3 pixels buffered -> pix_valid=0 after release, no stale output.
